// File: rtl/bt_pipe_out_source.sv
// bt_pipe_out_source: user-side block buffer feeding a Block Output Pipe endpoint.
//
// User logic pushes 16-bit words into a circular FIFO. ep_ready is raised while the
// FIFO is idle and holds at least one full block. Each ep_read then pops one word
// (read latency 1), and the block ends on the read that makes the count BLOCK_WORDS.
//
// Ports:
//   ti_clk         host-interface clock, all logic on its rising edge
//   ti_reset_n     synchronous active-low reset
//   wr_en, wr_data user push port (16-bit words)
//   full           FIFO holds 2**DEPTH_LOG2 words
//   fill_count     current number of words in the FIFO
//   ep_read        endpoint read strobe, pops one word
//   ep_blockstrobe one-cycle pulse marking the start of a block
//   ep_datain      word returned to the endpoint
//   ep_ready       a full block is available
//   block_active   a block transfer is in progress
//   overflow       sticky: write attempted while full
//   underflow      sticky: read attempted while empty
//   protocol_err   sticky: strobe/read sequence violated the rules
module bt_pipe_out_source #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned BLOCK_WORDS = 256
) (
    input  logic                  ti_clk,
    input  logic                  ti_reset_n,
    input  logic                  wr_en,
    input  logic [15:0]           wr_data,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   fill_count,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [15:0]           ep_datain,
    output logic                  ep_ready,
    output logic                  block_active,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  protocol_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    localparam cnt_t DepthCnt = cnt_t'(DEPTH);
    localparam cnt_t BlockCnt = cnt_t'(BLOCK_WORDS);

    typedef enum logic [0:0] {StIdle, StXfer} state_e;

    state_e      state_q, state_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    cnt_t        count_q, count_d;
    cnt_t        word_cnt_q, word_cnt_d;
    logic [15:0] data_q, data_d;
    logic        ready_q, ready_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        perr_q, perr_d;

    logic [15:0] mem [DEPTH];

    logic empty, is_full, pop, push;

    always_comb begin
        empty   = (count_q == '0);
        is_full = (count_q == DepthCnt);
        pop     = ep_read && !empty;
        // A pop in the same cycle frees a slot, so a push while full is still accepted.
        push    = wr_en && (!is_full || pop);

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        word_cnt_d  = word_cnt_q;
        data_d      = data_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        perr_d      = perr_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop)          data_d = mem[rd_ptr_q];
        else if (ep_read) data_d = 16'h0000;

        if (wr_en && !push)  overflow_d  = 1'b1;
        if (ep_read && !pop) underflow_d = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (ep_blockstrobe) begin
                    state_d    = StXfer;
                    // A read in the strobe cycle is the first word of the block.
                    word_cnt_d = ep_read ? cnt_t'(1) : '0;
                    if (!ready_q) perr_d = 1'b1;
                end else if (ep_read) begin
                    perr_d = 1'b1;
                end
            end
            StXfer: begin
                if (ep_blockstrobe) begin
                    perr_d     = 1'b1;
                    word_cnt_d = ep_read ? cnt_t'(1) : '0;
                end else if (ep_read) begin
                    // Underflowed reads still count toward the block.
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_d == BlockCnt) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registered from post-edge state and count.
        ready_d = (state_d == StIdle) && (count_d >= BlockCnt);
    end

    always_ff @(posedge ti_clk) begin
        if (!ti_reset_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            word_cnt_q  <= '0;
            data_q      <= 16'h0000;
            ready_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            word_cnt_q  <= word_cnt_d;
            data_q      <= data_d;
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            perr_q      <= perr_d;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge ti_clk) begin
        if (ti_reset_n && push) mem[wr_ptr_q] <= wr_data;
    end

    assign full         = is_full;
    assign fill_count   = count_q;
    assign ep_datain    = data_q;
    assign ep_ready     = ready_q;
    assign block_active = (state_q == StXfer);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign protocol_err = perr_q;

endmodule
